// File: rtl/pulse_seq_pkg.sv
// Shared definitions for the multi-channel pulse sequencer: run-mode
// encodings, configuration register map and the sequencer state type.
package pulse_seq_pkg;

    // Run modes held in the mode register
    localparam logic [1:0] MODE_OFF   = 2'd0;
    localparam logic [1:0] MODE_CONT  = 2'd1;
    localparam logic [1:0] MODE_BURST = 2'd2;
    localparam logic [1:0] MODE_TRIG  = 2'd3;

    // Configuration register map; channel k owns two consecutive entries
    localparam int ADDR_PERIOD  = 0;
    localparam int ADDR_MODE    = 1;
    localparam int ADDR_BURST   = 2;
    localparam int ADDR_CH_BASE = 3;

    // IDLE waits for a start, RUN counts periods, DONE emits the finish strobe
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Address of the delay register belonging to channel k
    function automatic int ch_delay_addr(input int k);
        return ADDR_CH_BASE + 2 * k;
    endfunction

    // Address of the width register belonging to channel k
    function automatic int ch_width_addr(input int k);
        return ADDR_CH_BASE + 2 * k + 1;
    endfunction

endpackage

// File: rtl/pulse_seq_gen_chan.sv
// One pulse channel: compares the shared period counter against this
// channel's delay/width window and registers the result, so every channel
// lines up with sync one clock after the counter value.
module pulse_chan
    import pulse_seq_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk_pll,
    input  logic             resetn,
    input  logic             run,
    input  logic [CNT_W-1:0] cnt,
    input  logic [CNT_W-1:0] delay,
    input  logic [CNT_W-1:0] width,
    output logic             pulse
);

    logic             pulse_d;
    logic             pulse_q;
    logic [CNT_W:0]   win_end;

    // Window test done one bit wider so delay+width can never wrap around
    always_comb begin
        win_end = {1'b0, delay} + {1'b0, width};
        pulse_d = run && (cnt >= delay) && ({1'b0, cnt} < win_end);
    end

    // Output register, cleared by the synchronous reset
    always_ff @(posedge clk_pll) begin
        if (!resetn) begin
            pulse_q <= 1'b0;
        end else begin
            pulse_q <= pulse_d;
        end
    end

    assign pulse = pulse_q;

endmodule

// File: rtl/pulse_seq_gen.sv
// Multi-channel pulse sequencer. A single period counter drives NCH
// delay/width channels and a sync marker. Configuration is written into
// shadow registers and copied to the active set while idle or on the last
// cycle of each period, so a running period never sees a half-written setup.
module pulse_seq_gen
    import pulse_seq_pkg::*;
#(
    parameter int NCH      = 4,
    parameter int CNT_W    = 32,
    parameter int SYNC_LEN = 4,
    parameter int ADDR_W   = 6
) (
    input  logic              clk_pll,
    input  logic              resetn,
    input  logic              cfg_we,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [CNT_W-1:0]  cfg_wdata,
    input  logic              trig,
    output logic              sync,
    output logic [NCH-1:0]    pulse,
    output logic              busy,
    output logic              done
);

    // Shadow (written by the config port) and active (used by the counter) sets
    logic [CNT_W-1:0]            period_sh_q, period_sh_d;
    logic [1:0]                  mode_sh_q, mode_sh_d;
    logic [CNT_W-1:0]            burst_sh_q, burst_sh_d;
    logic [NCH-1:0][CNT_W-1:0]   delay_sh_q, delay_sh_d;
    logic [NCH-1:0][CNT_W-1:0]   width_sh_q, width_sh_d;

    logic [CNT_W-1:0]            period_act_q, period_act_d;
    logic [1:0]                  mode_act_q, mode_act_d;
    logic [CNT_W-1:0]            burst_act_q, burst_act_d;
    logic [NCH-1:0][CNT_W-1:0]   delay_act_q, delay_act_d;
    logic [NCH-1:0][CNT_W-1:0]   width_act_q, width_act_d;

    // Sequencer state
    state_e                      state_q, state_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic [CNT_W-1:0]            pdone_q, pdone_d;
    logic                        start_pend_q, start_pend_d;

    // Trigger synchroniser and edge-detect history
    logic                        trig_s1_q, trig_s1_d;
    logic                        trig_s2_q, trig_s2_d;
    logic                        trig_s3_q, trig_s3_d;

    // Registered outputs
    logic                        sync_q, sync_d;
    logic                        busy_q, busy_d;
    logic                        done_q, done_d;

    // Combinational helpers
    logic                        mode_wr;
    logic                        mode_off_wr;
    logic                        start_wr;
    logic                        trig_rise;
    logic                        commit;
    logic                        period_last;
    logic                        chan_run;
    logic [CNT_W-1:0]            eff_period;
    logic [CNT_W:0]              pdone_inc;

    // Decode the config port: mode writes, and which writes request a start
    always_comb begin
        mode_wr     = cfg_we && (cfg_addr == ADDR_W'(ADDR_MODE));
        mode_off_wr = mode_wr && (cfg_wdata[1:0] == MODE_OFF);
        start_wr    = mode_wr && ((cfg_wdata[1:0] == MODE_CONT) ||
                                  (cfg_wdata[1:0] == MODE_BURST));
    end

    // Shadow register writes; unmapped addresses match nothing and are dropped
    always_comb begin
        period_sh_d = period_sh_q;
        mode_sh_d   = mode_sh_q;
        burst_sh_d  = burst_sh_q;
        delay_sh_d  = delay_sh_q;
        width_sh_d  = width_sh_q;
        if (cfg_we) begin
            if (cfg_addr == ADDR_W'(ADDR_PERIOD)) period_sh_d = cfg_wdata;
            if (cfg_addr == ADDR_W'(ADDR_MODE))   mode_sh_d   = cfg_wdata[1:0];
            if (cfg_addr == ADDR_W'(ADDR_BURST))  burst_sh_d  = cfg_wdata;
            for (int k = 0; k < NCH; k++) begin
                if (cfg_addr == ADDR_W'(ch_delay_addr(k))) delay_sh_d[k] = cfg_wdata;
                if (cfg_addr == ADDR_W'(ch_width_addr(k))) width_sh_d[k] = cfg_wdata;
            end
        end
    end

    // Two-flop synchroniser on trig plus one more stage for rising-edge detect
    always_comb begin
        trig_s1_d = trig;
        trig_s2_d = trig_s1_q;
        trig_s3_d = trig_s2_q;
        trig_rise = trig_s2_q && !trig_s3_q;
    end

    // Period length is never shorter than two cycles; flag the last count
    always_comb begin
        eff_period  = (period_act_q < CNT_W'(2)) ? CNT_W'(2) : period_act_q;
        period_last = (cnt_q == eff_period - CNT_W'(1));
        pdone_inc   = {1'b0, pdone_q} + (CNT_W + 1)'(1);
    end

    // Next-state logic: start conditions, period wrap, burst/single-shot finish
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pdone_d = pdone_q;
        commit  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                commit  = 1'b1;
                cnt_d   = '0;
                pdone_d = '0;
                if ((mode_sh_q == MODE_TRIG) && trig_rise) begin
                    state_d = ST_RUN;
                end else if (start_pend_q &&
                             ((mode_sh_q == MODE_CONT) ||
                              ((mode_sh_q == MODE_BURST) && (burst_sh_q != '0)))) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (period_last) begin
                    commit = 1'b1;
                    cnt_d  = '0;
                    if (mode_act_q == MODE_TRIG) begin
                        state_d = ST_DONE;
                    end else if (mode_act_q == MODE_BURST) begin
                        if (pdone_inc >= {1'b0, burst_act_q}) begin
                            state_d = ST_DONE;
                        end else begin
                            pdone_d = pdone_inc[CNT_W-1:0];
                        end
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                commit  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (mode_off_wr) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            pdone_d = '0;
        end
    end

    // A start request stays pending until the next commit consumes it
    always_comb begin
        start_pend_d = start_pend_q;
        if (commit) start_pend_d = 1'b0;
        if (start_wr) start_pend_d = 1'b1;
    end

    // Copy shadow to active on commit; an OFF write bypasses the shadow path
    always_comb begin
        period_act_d = period_act_q;
        mode_act_d   = mode_act_q;
        burst_act_d  = burst_act_q;
        delay_act_d  = delay_act_q;
        width_act_d  = width_act_q;
        if (commit) begin
            period_act_d = period_sh_q;
            mode_act_d   = mode_sh_q;
            burst_act_d  = burst_sh_q;
            delay_act_d  = delay_sh_q;
            width_act_d  = width_sh_q;
        end
        if (mode_off_wr) mode_act_d = MODE_OFF;
    end

    // Output decode from the current count; an OFF write blanks them at once
    always_comb begin
        chan_run = (state_q == ST_RUN) && !mode_off_wr;
        sync_d   = chan_run && (cnt_q < CNT_W'(SYNC_LEN));
        busy_d   = chan_run;
        done_d   = (state_q == ST_DONE) && !mode_off_wr;
    end

    // All sequential state, cleared together by the synchronous reset
    always_ff @(posedge clk_pll) begin
        if (!resetn) begin
            period_sh_q  <= '0;
            mode_sh_q    <= MODE_OFF;
            burst_sh_q   <= '0;
            delay_sh_q   <= '0;
            width_sh_q   <= '0;
            period_act_q <= '0;
            mode_act_q   <= MODE_OFF;
            burst_act_q  <= '0;
            delay_act_q  <= '0;
            width_act_q  <= '0;
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            pdone_q      <= '0;
            start_pend_q <= 1'b0;
            trig_s1_q    <= 1'b0;
            trig_s2_q    <= 1'b0;
            trig_s3_q    <= 1'b0;
            sync_q       <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            period_sh_q  <= period_sh_d;
            mode_sh_q    <= mode_sh_d;
            burst_sh_q   <= burst_sh_d;
            delay_sh_q   <= delay_sh_d;
            width_sh_q   <= width_sh_d;
            period_act_q <= period_act_d;
            mode_act_q   <= mode_act_d;
            burst_act_q  <= burst_act_d;
            delay_act_q  <= delay_act_d;
            width_act_q  <= width_act_d;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            pdone_q      <= pdone_d;
            start_pend_q <= start_pend_d;
            trig_s1_q    <= trig_s1_d;
            trig_s2_q    <= trig_s2_d;
            trig_s3_q    <= trig_s3_d;
            sync_q       <= sync_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    for (genvar k = 0; k < NCH; k++) begin : g_chan
        pulse_chan #(
            .CNT_W (CNT_W)
        ) u_chan (
            .clk_pll (clk_pll),
            .resetn  (resetn),
            .run     (chan_run),
            .cnt     (cnt_q),
            .delay   (delay_act_q[k]),
            .width   (width_act_q[k]),
            .pulse   (pulse[k])
        );
    end

    assign sync = sync_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule
